// File: rtl/mem_access.sv
// Memory-access stage: decodes load/store ops, runs a single outstanding data-memory
// request through an IDLE/REQ/DONE FSM, and registers the write-back results.
module mem_access #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [5:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o,
  output logic [1:0]  state_dbg
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          is_load, is_store, is_half, is_word, is_uns;
  logic          is_mem, misaligned;
  logic [3:0]    lane_sel;
  logic [31:0]   st_data, ld_data;
  logic [15:0]   half_v;
  logic [7:0]    byte_v;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_uns   = 1'b0;
    case (aluop_i)
      OP_LB:   is_load = 1'b1;
      OP_LH:   begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:   begin is_load = 1'b1; is_word = 1'b1; end
      OP_LBU:  begin is_load = 1'b1; is_uns = 1'b1; end
      OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; is_uns = 1'b1; end
      OP_SB:   is_store = 1'b1;
      OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));

  // Big-endian lanes: the lowest byte address maps to the most significant lane.
  always_comb begin
    lane_sel = 4'b0000;
    st_data  = 32'h0;
    ld_data  = 32'h0;
    half_v   = 16'h0;
    byte_v   = 8'h0;
    if (is_word) begin
      lane_sel = 4'b1111;
      st_data  = reg2_i;
      ld_data  = mem_rdata_i;
    end else if (is_half) begin
      lane_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      half_v   = mem_addr_i[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
      st_data  = {2{reg2_i[15:0]}};
      ld_data  = is_uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
    end else begin
      case (mem_addr_i[1:0])
        2'd0:    begin lane_sel = 4'b1000; byte_v = mem_rdata_i[31:24]; end
        2'd1:    begin lane_sel = 4'b0100; byte_v = mem_rdata_i[23:16]; end
        2'd2:    begin lane_sel = 4'b0010; byte_v = mem_rdata_i[15:8];  end
        default: begin lane_sel = 4'b0001; byte_v = mem_rdata_i[7:0];   end
      endcase
      st_data = {4{reg2_i[7:0]}};
      ld_data = is_uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
    end
  end

  // Handshake: stall_req_o=1 means upstream must hold every input stable; the memory
  // sees mem_req_o held high with constant address/lanes/data until a one-cycle
  // mem_ack_i completes it, or until the wait counter expires.
  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_sel_o   = 4'b0000;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    case (state)
      ST_IDLE: begin
        if (valid_i && is_mem && !misaligned) begin
          state_nxt   = ST_REQ;
          stall_req_o = rst;
        end
      end
      ST_REQ: begin
        stall_req_o = rst;
        mem_req_o   = 1'b1;
        mem_we_o    = is_store;
        mem_sel_o   = lane_sel;
        mem_addr_o  = {mem_addr_i[31:2], 2'b00};
        mem_wdata_o = is_store ? st_data : 32'h0;
        if (mem_ack_i || cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wd_o      <= 5'h0;
      wreg_o    <= 1'b0;
      wdata_o   <= 32'h0;
      adel_o    <= 1'b0;
      ades_o    <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd_o      <= 5'h0;
      wreg_o    <= 1'b0;
      wdata_o   <= 32'h0;
      adel_o    <= 1'b0;
      ades_o    <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (valid_i) begin
            if (!is_mem) begin
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else if (misaligned) begin
              adel_o <= is_load;
              ades_o <= is_store;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack_i) begin
            if (is_load) begin
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= ld_data;
            end
          end else if (cnt == CNT_LAST) begin
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: drivers push per-cycle expectations from an
// instruction-level model; a negedge monitor pops and compares.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [5:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, mem_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, mem_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic        adel_o, ades_o, bus_err_o;
  logic [1:0]  state_dbg;

  mem_access #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .adel_o(adel_o),
    .ades_o(ades_o), .bus_err_o(bus_err_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_mem;
    logic        stall;
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        adel;
    logic        ades;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Write-back outputs the model expects to be registered at the next edge.
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic        m_adel, m_ades, m_berr;

  logic [5:0] op_tab [0:13] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
                                6'h2B, 6'h00, 6'h08, 6'h0F, 6'h22, 6'h2A, 6'h3F};

  function automatic int op_size(input logic [5:0] op);
    if (op == 6'h23 || op == 6'h2B) return 4;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 1;
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [31:0] a);
    return (op_size(op) == 2 && a % 2 != 0) || (op_size(op) == 4 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] lanes(input logic [5:0] op, input logic [31:0] a);
    logic [3:0] one = 4'b1000;
    if (op_size(op) == 4) return 4'b1111;
    if (op_size(op) == 2) return (a % 4 >= 2) ? 4'b0011 : 4'b1100;
    return one >> (a % 4);
  endfunction

  function automatic logic [31:0] st_data(input logic [5:0] op, input logic [31:0] r);
    if (op_size(op) == 4) return r;
    if (op_size(op) == 2) return (r & 32'hFFFF) * 32'h0001_0001;
    return (r & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] ld_data(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (op_size(op) == 4) return rd;
    if (op_size(op) == 2) begin
      sh = (a % 4 >= 2) ? 0 : 16;
      v  = (rd >> sh) & 32'hFFFF;
      if (op == 6'h21 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    sh = (3 - int'(a % 4)) * 8;
    v  = (rd >> sh) & 32'hFF;
    if (op == 6'h20 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  task automatic bubble();
    m_wd = 5'h0; m_wreg = 1'b0; m_wdata = 32'h0;
    m_adel = 1'b0; m_ades = 1'b0; m_berr = 1'b0;
  endtask

  task automatic push(input logic chk, input logic stall, input logic req, input logic we,
                      input logic [3:0] sel, input logic [31:0] a, input logic [31:0] wdat);
    exp_t e;
    e.chk_mem = chk; e.stall = stall; e.req = req; e.we = we; e.sel = sel;
    e.addr = a; e.wdat = wdat; e.wd = m_wd; e.wreg = m_wreg; e.wdata = m_wdata;
    e.adel = m_adel; e.ades = m_ades; e.berr = m_berr;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    valid_i     = 1'($urandom_range(0, 1));
    aluop_i     = op_tab[$urandom_range(0, 13)];
    mem_addr_i  = $urandom;
    reg2_i      = $urandom;
    wd_i        = 5'($urandom);
    wreg_i      = 1'($urandom_range(0, 1));
    wdata_i     = $urandom;
    mem_rdata_i = $urandom;
    mem_ack_i   = 1'($urandom_range(0, 1));
  endtask

  // waits >= TMO means the memory never acknowledges.
  task automatic do_instr(input logic v, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdat, input int waits, input logic [31:0] rd);
    int  nreq;
    logic st;
    next_cycle();
    rst = 1'b1; valid_i = v; aluop_i = op; mem_addr_i = a; reg2_i = r2;
    wd_i = wd; wreg_i = wr; wdata_i = wdat;
    mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
    st = is_store_op(op);
    if (!v || !is_mem_op(op) || is_misaligned(op, a)) begin
      push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      bubble();
      if (v && !is_mem_op(op)) begin
        m_wd = wd; m_wreg = wr; m_wdata = wdat;
      end else if (v) begin
        m_adel = !st; m_ades = st;
      end
      return;
    end
    push(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bubble();
    nreq = (waits >= TMO) ? TMO : waits + 1;
    for (int i = 0; i < nreq; i++) begin
      next_cycle();
      mem_ack_i   = (waits < TMO && i == waits);
      mem_rdata_i = mem_ack_i ? rd : $urandom;
      push(1'b1, 1'b1, 1'b1, st, lanes(op, a), a & 32'hFFFF_FFFC, st ? st_data(op, r2) : 32'h0);
    end
    bubble();
    if (waits >= TMO) m_berr = 1'b1;
    else if (!st) begin
      m_wd = wd; m_wreg = wr; m_wdata = ld_data(op, a, rd);
    end
    next_cycle();
    randomize_inputs();
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bubble();
  endtask

  task automatic do_reset_mid_req();
    next_cycle();
    rst = 1'b1; valid_i = 1'b1; aluop_i = 6'h23; mem_addr_i = 32'h0000_5000;
    reg2_i = $urandom; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = $urandom; mem_ack_i = 1'b0;
    push(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bubble();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mem_ack_i = 1'b0;
      push(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_5000, 32'h0);
    end
    next_cycle();
    rst = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    valid_i = 1'b1; aluop_i = 6'h2B; mem_addr_i = 32'h0000_6000; mem_ack_i = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b1; valid_i = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_req_o", 32'(stall_req_o), 32'(e.stall));
      if (e.chk_mem) begin
        chk("mem_req_o", 32'(mem_req_o), 32'(e.req));
        chk("mem_we_o", 32'(mem_we_o), 32'(e.we));
        chk("mem_sel_o", 32'(mem_sel_o), 32'(e.sel));
        chk("mem_addr_o", mem_addr_o, e.addr);
        chk("mem_wdata_o", mem_wdata_o, e.wdat);
      end
      chk("wd_o", 32'(wd_o), 32'(e.wd));
      chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
      chk("wdata_o", wdata_o, e.wdata);
      chk("adel_o", 32'(adel_o), 32'(e.adel));
      chk("ades_o", 32'(ades_o), 32'(e.ades));
      chk("bus_err_o", 32'(bus_err_o), 32'(e.berr));
    end
  end

  initial begin
    rst = 1'b0; valid_i = 1'b0; aluop_i = 6'h0; mem_addr_i = 32'h0; reg2_i = 32'h0;
    wd_i = 5'h0; wreg_i = 1'b0; wdata_i = 32'h0; mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    bubble();
    // Held in reset with a valid aligned load present: no stall, all outputs zero.
    next_cycle();
    valid_i = 1'b1; aluop_i = 6'h23; mem_addr_i = 32'h0000_0100;
    push(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    do_instr(1'b1, 6'h20, 32'h0000_1001, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h12F4_5678);
    do_instr(1'b1, 6'h25, 32'h0000_2002, 32'h0, 5'd4, 1'b1, 32'h0, 3, 32'hAAAA_8001);
    do_instr(1'b1, 6'h28, 32'h0000_3003, 32'h0000_00AB, 5'd5, 1'b1, 32'h0, 1, 32'h0);
    do_instr(1'b1, 6'h23, 32'h0000_4002, 32'h0, 5'd6, 1'b1, 32'h0, 0, 32'h0);
    do_instr(1'b1, 6'h00, 32'h0, 32'h0, 5'd7, 1'b1, 32'h7, 0, 32'h0);
    do_instr(1'b1, 6'h21, 32'h0000_7000, 32'h0, 5'd8, 1'b1, 32'h0, 2, 32'h9ABC_1234);
    do_instr(1'b1, 6'h29, 32'h0000_7001, 32'h1234_5678, 5'd8, 1'b1, 32'h0, 0, 32'h0);
    do_instr(1'b1, 6'h2B, 32'h0000_8004, 32'hDEAD_BEEF, 5'd1, 1'b1, 32'h0, 0, 32'h0);
    do_instr(1'b0, 6'h23, 32'h0000_9000, 32'h0, 5'd2, 1'b1, 32'h55, 0, 32'h0);
    do_instr(1'b1, 6'h23, 32'h0000_A000, 32'h0, 5'd2, 1'b1, 32'h0, TMO, 32'h0);
    do_reset_mid_req();

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = op_tab[$urandom_range(0, 13)];
      do_instr(1'($urandom_range(0, 7) != 0), op, $urandom, $urandom, 5'($urandom),
               1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TMO), $urandom);
    end

    next_cycle();
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the number of REQ-state cycles without mem_ack_i before the access is abandoned.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-004 valid_i  input  1  an instruction from the execute stage is present.
REQ-005 aluop_i  input  6  instruction opcode field inst[31:26].
REQ-006 mem_addr_i  input  32  effective byte address (base + sign-extended offset).
REQ-007 reg2_i  input  32  store source register value.
REQ-008 wd_i / wreg_i / wdata_i  input  5/1/32  destination register, write enable, and ALU result of the execute stage.
REQ-009 wd_o / wreg_o / wdata_o  output  5/1/32  registered write-back destination, enable, and data.
REQ-010 stall_req_o  output  1  combinational; upstream holds all inputs stable while it is 1.
REQ-011 mem_req_o / mem_we_o  output  1/1  data-memory request and write strobe.
REQ-012 mem_addr_o / mem_sel_o / mem_wdata_o  output  32/4/32  word-aligned address, byte lanes, and store data.
REQ-013 mem_rdata_i / mem_ack_i  input  32/1  read data and one-cycle completion strobe.
REQ-014 adel_o / ades_o / bus_err_o  output  1/1/1  one-cycle registered pulses for load misalignment, store misalignment, and memory timeout.

Function
REQ-015 Memory opcodes SHALL be LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, and SW 0x2B; all other opcodes are non-memory.
REQ-016 A non-memory op with valid_i=1 in IDLE SHALL register wd_i, wreg_i, and wdata_i to the outputs at the next edge (1-cycle latency), with stall_req_o=0.
REQ-017 valid_i=0 in IDLE SHALL register a bubble: wreg_o=0, wd_o=0, wdata_o=0.
REQ-018 An op is misaligned when it is a halfword op with addr[0]=1 or a word op with addr[1:0]!=0.
REQ-019 A misaligned op SHALL issue no request and SHALL not stall; the next edge registers a bubble and pulses adel_o for loads or ades_o for stores.
REQ-020 The FSM SHALL have states IDLE, REQ, and DONE.
REQ-021 IDLE->REQ SHALL occur on an aligned memory op with valid_i=1; stall_req_o=1 in that IDLE cycle, and a bubble is registered.
REQ-022 In REQ, mem_req_o=1, mem_we_o=1 for stores, and mem_addr_o={addr[31:2],2'b00} SHALL be held constant; stall_req_o=1 and the write-back outputs hold the bubble.
REQ-023 Byte lanes are big-endian: byte at addr[1:0] 0/1/2/3 SHALL use mem_sel_o 1000/0100/0010/0001.
REQ-024 Halfword lanes: addr[1]=0 SHALL use mem_sel_o 1100 and addr[1]=1 SHALL use 0011; word SHALL use 1111.
REQ-025 Store data SHALL be SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, and SW reg2.
REQ-026 Load data SHALL be extracted from the selected lanes; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word through.
REQ-027 REQ with mem_ack_i=1 SHALL go to DONE; loads register wd_o=wd_i, wreg_o=wreg_i, and the extracted data, while stores register a bubble.
REQ-028 A cycle counter SHALL clear on IDLE->REQ and increment each REQ cycle without ack.
REQ-029 When the counter reaches MEM_TIMEOUT-1 without ack, the FSM SHALL go to DONE, pulse bus_err_o, register a bubble, and drop mem_req_o.
REQ-030 In DONE, stall_req_o=0, the write-back outputs hold for exactly that cycle, and the inputs are ignored; the next edge goes to IDLE and registers a bubble.
REQ-031 mem_ack_i SHALL be ignored outside REQ.
REQ-032 Outside REQ, mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, and mem_wdata_o SHALL all be 0.

Reset
REQ-033 An edge with rst=0 SHALL force IDLE, zero the counter, and set every output to 0, including a mid-REQ abort (mem_req_o=0 next cycle).
REQ-034 While rst=0, stall_req_o SHALL be 0.

Verification
V-1 Load: LB with addr 0x1001 and ack on the first REQ cycle, rdata 0x12F45678 -> mem_sel_o 0100, mem_addr_o 0x1000; wdata_o 0xFFFFFFF4 in DONE; stall 1,1,0.
V-2 Load: LHU with addr 0x2002, rdata 0xAAAA8001, and ack after 3 wait cycles -> mem_sel_o 0011; wdata_o 0x00008001; stall high for 5 cycles.
V-3 Store: SB with addr 0x3003 and reg2 0x000000AB -> mem_we_o 1, mem_sel_o 0001, mem_wdata_o 0xABABABAB; wreg_o 0 in DONE.
V-4 Misaligned/pass-through: LW at 0x4002 -> no mem_req_o, adel_o one pulse, no stall; ADDU with wdata_i 7 -> wdata_o 7 after 1 cycle.
V-5 Timeout and reset: no ack with MEM_TIMEOUT=4 -> bus_err_o pulse after 4 REQ cycles; separately, rst=0 during REQ -> all outputs 0 the next cycle.
